instruction_fetcher: RTL and testbench
======================================

Name: instruction_fetcher

Overview:
- Upstream neighbour of the instruction queue; owns the fetch PC.
- Looks up a direct-mapped instruction cache and fetches from the memory controller on a miss.
- Pushes one {instruction, pc} per emission into the instruction queue over its `instruction_ready`/`instruction_in`/`pc_in` interface.
- Redirects the PC on a ROB flush (mispredict or jump).

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- ICACHE_IDX_W, 6, log2 of cache lines. One 32-bit word per line; 64 lines by default.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  pause when low; all state holds
- isq_is_full  in  1  instruction queue full
- instruction_ready  out  1  registered; one-cycle push strobe to the queue
- instruction_out  out  32  instruction word, valid while instruction_ready=1
- pc_out  out  32  PC of instruction_out
- mem_req_valid  out  1  miss request to the memory controller
- mem_req_addr  out  32  word-aligned miss address
- mem_resp_valid  in  1  one-cycle response strobe
- mem_resp_data  in  32  instruction word returned by memory
- rob_flush  in  1  redirect request
- rob_target_pc  in  32  redirect target

Behaviour:
- Reset (rst_in=0, async):
  - pc=RESET_PC, state=FETCH.
  - All cache valid bits cleared.
  - instruction_ready=0, mem_req_valid=0, mem_req_addr=0, instruction_out=0, pc_out=0, drop=0.
- rdy_in=0: no register changes; outputs hold their values.
- Cache geometry:
  - index = pc[ICACHE_IDX_W+1:2]; tag = pc[31:ICACHE_IDX_W+2]; pc[1:0] ignored.
  - hit = valid[index] && tag match.
- Emit condition: can_emit = !isq_is_full && !instruction_ready. This forces at most one push every two cycles, so a push already in flight can never overrun the queue's full flag.
- instruction_ready defaults to 0 on every active edge unless set by an emission below.
- FETCH state:
  - If rob_flush: pc<=rob_target_pc; no emit, no request.
  - Else if can_emit and hit: next edge instruction_ready<=1, instruction_out<=cache data, pc_out<=pc, pc<=pc+4.
  - Else if can_emit and miss: mem_req_valid<=1, mem_req_addr<={pc[31:2],2'b00}; go to WAIT.
  - Else: stall; no change.
- WAIT state:
  - mem_req_valid and mem_req_addr stay stable until mem_resp_valid.
  - rob_flush without a response: pc<=rob_target_pc, drop<=1, stay in WAIT.
  - On mem_resp_valid: fill the cache line (valid=1, tag, data) for mem_req_addr; mem_req_valid<=0; state<=FETCH.
    - If drop=0 and no flush in the same cycle: instruction_ready<=1, instruction_out<=mem_resp_data, pc_out<=pc, pc<=pc+4.
    - If drop=1 or rob_flush in the same cycle: no emit; on flush, pc<=rob_target_pc; drop<=0.
  - A response emits even if isq_is_full rose during WAIT. This is legal because emission was granted when the request was issued and instruction_ready was 0 throughout WAIT.
- Flush priority: rob_flush always overrides a same-cycle hit emission. A strobe already registered (instruction_ready=1) is not recalled; the downstream flush handles it.
- PC arithmetic is 32-bit and wraps 32'hFFFFFFFC -> 0.
- Memory interface: at most one outstanding request; mem_resp_valid outside WAIT is ignored.
- Reset asserted in WAIT abandons the request; mem_req_valid=0 immediately.

Test Plan:
- Cold start, RESET_PC=0, memory latency 3, returning 32'h00000013 at every address → requests at 0, 4, 8. Each response produces instruction_ready one cycle later with pc_out=0/4/8 and instruction_out=32'h13.
- Loop re-fetch of 0..8 after warm-up → no mem_req_valid. instruction_ready asserts every second cycle with pc_out=0, 4, 8.
- isq_is_full=1 for 5 cycles during hits → no instruction_ready and pc unchanged. First strobe follows the first cycle with isq_is_full=0.
- In WAIT for addr 0x40: rob_flush with target 0x100, response 2 cycles later → no emit; line 0x40 is filled; next request is 0x100. Also repeat with flush and response in the same cycle.
- rdy_in=0 for 4 cycles while instruction_ready=1 → strobe and pc_out held. After resume the strobe clears one cycle later.
- rst_in pulsed low mid-WAIT → mem_req_valid=0 and instruction_ready=0 asynchronously; pc=RESET_PC; a previously cached address misses again.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// Fetch-side bus bundle: instruction-queue push, memory miss port and ROB redirect.
// master = the fetcher, slave = its environment (queue, memory controller, ROB).
interface instruction_fetcher_if;
  logic        isq_is_full;
  logic        instruction_ready;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        rob_flush;
  logic [31:0] rob_target_pc;

  modport master (
    input  isq_is_full, mem_resp_valid, mem_resp_data, rob_flush, rob_target_pc,
    output instruction_ready, instruction_out, pc_out, mem_req_valid, mem_req_addr
  );

  modport slave (
    output isq_is_full, mem_resp_valid, mem_resp_data, rob_flush, rob_target_pc,
    input  instruction_ready, instruction_out, pc_out, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: owns the fetch PC, looks up a direct-mapped one-word-per-line
// I-cache, refills from memory on a miss and pushes {instruction, pc} to the queue.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_IDX_W = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  instruction_fetcher_if.master bus
);
  localparam int unsigned LINES = 1 << ICACHE_IDX_W;
  localparam int unsigned TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic {S_FETCH, S_WAIT} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic        drop_q, drop_nxt;
  logic        ready_q, ready_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic [31:0] pc_out_q, pc_out_nxt;
  logic        req_valid_q, req_valid_nxt;
  logic [31:0] req_addr_q, req_addr_nxt;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [ICACHE_IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0]        tag, fill_tag;
  logic                    hit, can_emit, fill_en;

  assign idx      = pc_q[ICACHE_IDX_W+1:2];
  assign tag      = pc_q[31:ICACHE_IDX_W+2];
  assign fill_idx = req_addr_q[ICACHE_IDX_W+1:2];
  assign fill_tag = req_addr_q[31:ICACHE_IDX_W+2];
  assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
  // A registered strobe blocks the next emission so a push in flight cannot overrun the queue.
  assign can_emit = !bus.isq_is_full && !ready_q;

  always_comb begin
    state_nxt     = state_q;
    pc_nxt        = pc_q;
    drop_nxt      = drop_q;
    ready_nxt     = 1'b0;
    instr_nxt     = instr_q;
    pc_out_nxt    = pc_out_q;
    req_valid_nxt = req_valid_q;
    req_addr_nxt  = req_addr_q;
    fill_en       = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (bus.rob_flush) begin
          pc_nxt = bus.rob_target_pc;
        end else if (can_emit && hit) begin
          ready_nxt  = 1'b1;
          instr_nxt  = data_mem[idx];
          pc_out_nxt = pc_q;
          pc_nxt     = pc_q + 32'd4;
        end else if (can_emit) begin
          req_valid_nxt = 1'b1;
          req_addr_nxt  = {pc_q[31:2], 2'b00};
          state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill_en       = 1'b1;
          req_valid_nxt = 1'b0;
          state_nxt     = S_FETCH;
          drop_nxt      = 1'b0;
          if (bus.rob_flush) begin
            pc_nxt = bus.rob_target_pc;
          end else if (!drop_q) begin
            ready_nxt  = 1'b1;
            instr_nxt  = bus.mem_resp_data;
            pc_out_nxt = pc_q;
            pc_nxt     = pc_q + 32'd4;
          end
        end else if (bus.rob_flush) begin
          // Redirect while the miss is outstanding: the returning word is stale.
          pc_nxt   = bus.rob_target_pc;
          drop_nxt = 1'b1;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      ready_q     <= 1'b0;
      instr_q     <= 32'h0;
      pc_out_q    <= 32'h0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0;
    end else if (rdy_in) begin
      state_q     <= state_nxt;
      pc_q        <= pc_nxt;
      drop_q      <= drop_nxt;
      ready_q     <= ready_nxt;
      instr_q     <= instr_nxt;
      pc_out_q    <= pc_out_nxt;
      req_valid_q <= req_valid_nxt;
      req_addr_q  <= req_addr_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (rdy_in && fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays need no reset: valid bits gate every lookup.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_resp_data;
    end
  end

  assign bus.instruction_ready = ready_q;
  assign bus.instruction_out   = instr_q;
  assign bus.pc_out            = pc_out_q;
  assign bus.mem_req_valid     = req_valid_q;
  assign bus.mem_req_addr      = req_addr_q;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: table of single fetch steps plus hand-written
// sequences for stalls, redirects during a miss, rdy_in hold and async reset.
module tb_instruction_fetcher;
  localparam logic [31:0] K = 32'h5A5A_0013;

  typedef struct {
    bit          mode;
    bit          flush;
    logic [31:0] target;
    bit          miss;
    logic [31:0] pc;
    logic [31:0] instr;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  bit          mem_auto;
  bit          mem_mode;
  logic        auto_v, man_v;
  logic [31:0] auto_d, man_d;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   req_seen = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          push_cyc[$];
  row_t        rows[14];

  instruction_fetcher_if bus();

  instruction_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_W(6)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .rdy_in(rdy),
    .bus   (bus)
  );

  assign bus.mem_resp_valid = mem_auto ? auto_v : man_v;
  assign bus.mem_resp_data  = mem_auto ? auto_d : man_d;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_mode ? (a ^ K) : 32'h13;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  function automatic void fail_note(input string name, input string msg);
    tests++;
    fails++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endfunction

  // One clock: observe pushes/requests on the falling edge, return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.mem_req_valid && !req_seen) req_log.push_back(bus.mem_req_addr);
    req_seen = bus.mem_req_valid;
    if (bus.instruction_ready && rdy) begin
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        fail_note("unexpected_push", $sformatf("got pc %h instr %h, none expected",
                  bus.pc_out, bus.instruction_out));
      end else begin
        e = exp_q.pop_front();
        chk("push_pc", bus.pc_out, e.pc);
        chk("push_instr", bus.instruction_out, e.instr);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_flush(input logic [31:0] target);
    bus.rob_flush     = 1'b1;
    bus.rob_target_pc = target;
    tick();
    bus.rob_flush     = 1'b0;
  endtask

  task automatic fetch_step(input row_t r);
    int n0;
    int w;
    exp_t e;
    if (r.flush) do_flush(r.target);
    mem_mode = r.mode;
    e.pc = r.pc;
    e.instr = r.instr;
    exp_q.push_back(e);
    n0 = req_log.size();
    bus.isq_is_full = 1'b0;
    tick();
    bus.isq_is_full = 1'b1;
    w = 0;
    while (exp_q.size() != 0 && w < 30) begin
      tick();
      w++;
    end
    if (exp_q.size() != 0) begin
      fail_note("step_timeout", $sformatf("no push for pc %h within 30 cycles", r.pc));
      exp_q.delete();
    end
    tick();
    chk("req_count", 32'(req_log.size()), 32'(n0 + (r.miss ? 1 : 0)));
    if (r.miss && req_log.size() > n0) chk("req_addr", req_log[req_log.size()-1], r.pc);
  endtask

  // Memory model: answers the outstanding request three cycles after it appears.
  initial begin
    int cnt;
    cnt = 0;
    auto_v = 1'b0;
    auto_d = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_auto || auto_v) begin
        auto_v = 1'b0;
        cnt = 0;
      end else if (bus.mem_req_valid) begin
        cnt++;
        if (cnt == 3) begin
          auto_v = 1'b1;
          auto_d = mem_word(bus.mem_req_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    row_t r;
    int   n0;

    rows[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 32'h0000_0013};
    rows[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0004, 32'h0000_0013};
    rows[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 32'h0000_0013};
    rows[3]  = '{1'b0, 1'b1, 32'h0,        1'b0, 32'h0000_0000, 32'h0000_0013};
    rows[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 32'h0000_0013};
    rows[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_0008, 32'h0000_0013};
    rows[6]  = '{1'b1, 1'b1, 32'h1010,     1'b1, 32'h0000_1010, 32'h5A5A_1003};
    rows[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_1014, 32'h5A5A_1007};
    rows[8]  = '{1'b1, 1'b1, 32'h0,        1'b0, 32'h0000_0000, 32'h0000_0013};
    rows[9]  = '{1'b1, 1'b1, 32'h300,      1'b1, 32'h0000_0300, 32'h5A5A_0313};
    rows[10] = '{1'b1, 1'b1, 32'h0,        1'b1, 32'h0000_0000, 32'h5A5A_0013};
    rows[11] = '{1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_FFEF};
    rows[12] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0000, 32'h5A5A_0013};
    rows[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_0004, 32'h0000_0013};

    rst_n = 1'b0;
    rdy = 1'b1;
    mem_auto = 1'b1;
    mem_mode = 1'b0;
    man_v = 1'b0;
    man_d = 32'h0;
    bus.isq_is_full = 1'b1;
    bus.rob_flush = 1'b0;
    bus.rob_target_pc = 32'h0;
    tick();
    tick();
    chk("rst_ready", 32'(bus.instruction_ready), 32'h0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_instr", bus.instruction_out, 32'h0);
    chk("rst_pc_out", bus.pc_out, 32'h0);
    rst_n = 1'b1;
    tick();

    // Cold misses, warm hits, aliasing eviction and PC wrap.
    for (int i = 0; i < 14; i++) fetch_step(rows[i]);

    // Queue full during a hit: nothing moves until it clears.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_no_strobe", 32'(bus.instruction_ready), 32'h0);
      chk("full_no_req", 32'(bus.mem_req_valid), 32'h0);
    end
    e.pc = 32'h8;
    e.instr = 32'h13;
    exp_q.push_back(e);
    bus.isq_is_full = 1'b0;
    tick();
    bus.isq_is_full = 1'b1;
    chk("full_release_strobe", 32'(bus.instruction_ready), 32'h1);
    tick();
    chk("full_release_drained", 32'(exp_q.size()), 32'h0);

    // Back-to-back hits: one strobe every second cycle, no memory traffic.
    do_flush(32'h0);
    n0 = req_log.size();
    e.pc = 32'h0; e.instr = K;     exp_q.push_back(e);
    e.pc = 32'h4; e.instr = 32'h13; exp_q.push_back(e);
    e.pc = 32'h8; e.instr = 32'h13; exp_q.push_back(e);
    push_cyc.delete();
    bus.isq_is_full = 1'b0;
    repeat (5) tick();
    bus.isq_is_full = 1'b1;
    tick();
    tick();
    chk("loop_drained", 32'(exp_q.size()), 32'h0);
    chk("loop_push_count", 32'(push_cyc.size()), 32'h3);
    for (int i = 1; i < push_cyc.size(); i++)
      chk("loop_gap", 32'(push_cyc[i] - push_cyc[i-1]), 32'h2);
    chk("loop_no_req", 32'(req_log.size()), 32'(n0));
    exp_q.delete();

    // Redirect while waiting, response two cycles later: dropped but cached.
    mem_auto = 1'b0;
    do_flush(32'h40);
    bus.isq_is_full = 1'b0;
    tick();
    bus.isq_is_full = 1'b1;
    chk("wait_req_valid", 32'(bus.mem_req_valid), 32'h1);
    chk("wait_req_addr", bus.mem_req_addr, 32'h40);
    tick();
    do_flush(32'h100);
    chk("wait_req_stable", 32'(bus.mem_req_valid), 32'h1);
    chk("wait_addr_stable", bus.mem_req_addr, 32'h40);
    tick();
    man_v = 1'b1;
    man_d = 32'hC0DE_0040;
    tick();
    man_v = 1'b0;
    chk("drop_req_cleared", 32'(bus.mem_req_valid), 32'h0);
    chk("drop_no_strobe", 32'(bus.instruction_ready), 32'h0);
    tick();
    chk("drop_no_strobe2", 32'(bus.instruction_ready), 32'h0);
    mem_auto = 1'b1;
    r = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0000_0100, 32'h5A5A_0113};
    fetch_step(r);
    r = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h0000_0040, 32'hC0DE_0040};
    fetch_step(r);

    // Redirect in the same cycle as the response.
    mem_auto = 1'b0;
    do_flush(32'h80);
    bus.isq_is_full = 1'b0;
    tick();
    bus.isq_is_full = 1'b1;
    chk("same_req_addr", bus.mem_req_addr, 32'h80);
    tick();
    man_v = 1'b1;
    man_d = 32'hC0DE_0080;
    bus.rob_flush = 1'b1;
    bus.rob_target_pc = 32'h1C0;
    tick();
    man_v = 1'b0;
    bus.rob_flush = 1'b0;
    chk("same_req_cleared", 32'(bus.mem_req_valid), 32'h0);
    chk("same_no_strobe", 32'(bus.instruction_ready), 32'h0);
    tick();
    chk("same_no_strobe2", 32'(bus.instruction_ready), 32'h0);
    mem_auto = 1'b1;
    r = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0000_01C0, 32'h5A5A_01D3};
    fetch_step(r);
    r = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h0000_0080, 32'hC0DE_0080};
    fetch_step(r);

    // rdy_in low while a strobe is up: strobe and pc_out hold.
    do_flush(32'h1010);
    e.pc = 32'h1010;
    e.instr = 32'h5A5A_1003;
    exp_q.push_back(e);
    bus.isq_is_full = 1'b0;
    tick();
    bus.isq_is_full = 1'b1;
    rdy = 1'b0;
    chk("hold_strobe_set", 32'(bus.instruction_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_strobe", 32'(bus.instruction_ready), 32'h1);
      chk("hold_pc_out", bus.pc_out, 32'h1010);
    end
    rdy = 1'b1;
    tick();
    chk("resume_strobe_clear", 32'(bus.instruction_ready), 32'h0);
    chk("resume_drained", 32'(exp_q.size()), 32'h0);

    // Async reset mid-miss: request abandoned, PC and valid bits cleared.
    r = '{1'b1, 1'b1, 32'h0, 1'b1, 32'h0, K};
    fetch_step(r);
    r = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, K};
    fetch_step(r);
    mem_auto = 1'b0;
    do_flush(32'h2020);
    bus.isq_is_full = 1'b0;
    tick();
    bus.isq_is_full = 1'b1;
    chk("prerst_req_valid", 32'(bus.mem_req_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("arst_ready", 32'(bus.instruction_ready), 32'h0);
    chk("arst_req_addr", bus.mem_req_addr, 32'h0);
    chk("arst_pc_out", bus.pc_out, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    mem_auto = 1'b1;
    r = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, K};
    fetch_step(r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
